// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO registers for the MIPS EX stage.
// mult/div results are computed from latched operands and committed when the busy countdown expires.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             Stall
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state;
    op_t              op_q;
    op_t              issue_op;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             is_long;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               div_signed;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               div_zero;

    assign issue_op = op_t'(MDUOp);

    always_comb begin
        is_long = 1'b0;
        case (issue_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_long = 1'b1;
            default:                            is_long = 1'b0;
        endcase
    end

    assign Stall = Busy | (Start & is_long);

    // Sign-extending to 2*WIDTH makes the unsigned product equal the signed one modulo 2^(2*WIDTH).
    always_comb begin
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end

    // Signed division on magnitudes: MIN/-1 falls out as quotient MIN, remainder 0.
    always_comb begin
        div_signed = (op_q == OP_DIV);
        neg_a      = div_signed & a_q[WIDTH-1];
        neg_b      = div_signed & b_q[WIDTH-1];
        mag_a      = neg_a ? ('0 - a_q) : a_q;
        mag_b      = neg_b ? ('0 - b_q) : b_q;
        div_zero   = (b_q == '0);
        divisor    = div_zero ? WIDTH'(1) : mag_b;
        q_mag      = mag_a / divisor;
        r_mag      = mag_a % divisor;
        quot       = (neg_a ^ neg_b) ? ('0 - q_mag) : q_mag;
        rem        = neg_a ? ('0 - r_mag) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        case (issue_op)
                            OP_MULT, OP_MULTU: begin
                                op_q  <= issue_op;
                                a_q   <= SrcA;
                                b_q   <= SrcB;
                                cnt   <= CW'(MULT_CYCLES);
                                Busy  <= 1'b1;
                                state <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q  <= issue_op;
                                a_q   <= SrcA;
                                b_q   <= SrcB;
                                cnt   <= CW'(DIV_CYCLES);
                                Busy  <= 1'b1;
                                state <= S_RUN;
                            end
                            OP_MTHI: HI <= SrcA;
                            OP_MTLO: LO <= SrcA;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (cnt == CW'(1)) begin
                        case (op_q)
                            OP_MULT:  {HI, LO} <= prod_s;
                            OP_MULTU: {HI, LO} <= prod_u;
                            OP_DIV, OP_DIVU: begin
                                if (!div_zero) begin
                                    LO <= quot;
                                    HI <= rem;
                                end
                            end
                            default: ;
                        endcase
                        cnt   <= '0;
                        Busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues per-cycle expectations, a negedge monitor compares them.
// Instance 0 uses default parameters; instance 1 is WIDTH=8, MULT_CYCLES=1, DIV_CYCLES=3.
module tb_mdu;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int K_HI = 0, K_LO = 1, K_BUSY = 2, K_STALL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start8;
    logic [2:0]  op0, op8;
    logic [31:0] a0, b0;
    logic [7:0]  a8, b8;
    logic [31:0] hi0, lo0;
    logic [7:0]  hi8, lo8;
    logic        busy0, stall0, busy8, stall8;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        int          inst;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        sb[$];
    logic [31:0] m_hi[2];
    logic [31:0] m_lo[2];

    mdu dut0 (
        .clk(clk), .reset(reset), .Start(start0), .MDUOp(op0),
        .SrcA(a0), .SrcB(b0), .HI(hi0), .LO(lo0), .Busy(busy0), .Stall(stall0)
    );

    mdu #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
        .clk(clk), .reset(reset), .Start(start8), .MDUOp(op8),
        .SrcA(a8), .SrcB(b8), .HI(hi8), .LO(lo8), .Busy(busy8), .Stall(stall8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] actual(input int inst, input int kind);
        logic [31:0] v;
        v = '0;
        if (inst == 0) begin
            case (kind)
                K_HI:    v = hi0;
                K_LO:    v = lo0;
                K_BUSY:  v = {31'd0, busy0};
                default: v = {31'd0, stall0};
            endcase
        end else begin
            case (kind)
                K_HI:    v = {24'd0, hi8};
                K_LO:    v = {24'd0, lo8};
                K_BUSY:  v = {31'd0, busy8};
                default: v = {31'd0, stall8};
            endcase
        end
        return v;
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_HI:    return "HI";
            K_LO:    return "LO";
            K_BUSY:  return "Busy";
            default: return "Stall";
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [31:0] act;
                act   = actual(sb[i].inst, sb[i].kind);
                n_cmp = n_cmp + 1;
                if (sb[i].cyc < cyc) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s inst%0d %s: check for cycle %0d never sampled (now %0d)",
                             sb[i].name, sb[i].inst, kname(sb[i].kind), sb[i].cyc, cyc);
                end else if (act !== sb[i].exp) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s inst%0d %s cyc%0d: got %h expected %h",
                             sb[i].name, sb[i].inst, kname(sb[i].kind), cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input int c, input int inst, input int kind, input logic [31:0] v,
                        input string name);
        chk_t e;
        e.cyc  = c;
        e.inst = inst;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input int inst, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_stall, input string name,
                         output int c);
        c = cyc;
        if (inst == 0) begin
            start0 = 1'b1; op0 = op; a0 = a; b0 = b;
        end else begin
            start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end
        push(c, inst, K_STALL, {31'd0, exp_stall}, name);
        step(1);
        start0 = 1'b0; op0 = OP_NONE;
        start8 = 1'b0; op8 = OP_NONE;
    endtask

    // HI/LO hold their previous values while busy, then take the new result with Busy low.
    task automatic push_checks(input int inst, input int c, input int n, input logic [31:0] hi,
                               input logic [31:0] lo, input string name);
        for (int k = 0; k < n; k++) begin
            push(c + 1 + k, inst, K_BUSY, 32'd1, name);
            push(c + 1 + k, inst, K_HI, m_hi[inst], name);
            push(c + 1 + k, inst, K_LO, m_lo[inst], name);
        end
        push(c + 1 + n, inst, K_BUSY, 32'd0, name);
        push(c + 1 + n, inst, K_HI, hi, name);
        push(c + 1 + n, inst, K_LO, lo, name);
        m_hi[inst] = hi;
        m_lo[inst] = lo;
    endtask

    task automatic do_op(input int inst, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] hi,
                         input logic [31:0] lo, input string name);
        int c;
        issue(inst, op, a, b, n > 0, name, c);
        push_checks(inst, c, n, hi, lo, name);
        step(n);
    endtask

    initial begin
        int c;
        reset  = 1'b1;
        start0 = 1'b0; op0 = OP_NONE; a0 = '0; b0 = '0;
        start8 = 1'b0; op8 = OP_NONE; a8 = '0; b8 = '0;
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(cyc, i, K_HI, 32'd0, "reset");
            push(cyc, i, K_LO, 32'd0, "reset");
            push(cyc, i, K_BUSY, 32'd0, "reset");
            push(cyc, i, K_STALL, 32'd0, "reset");
        end
        step(1);

        do_op(0, OP_MULT,  32'hFFFF_FFFD, 32'd5,        5,  32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");
        do_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        do_op(0, OP_MTHI,  32'h1234_5678, 32'd0,        0,  32'h1234_5678, 32'h0000_0001, "mthi");
        do_op(0, OP_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
        do_op(0, OP_DIVU,  32'd7,         32'd2,        10, 32'h0000_0001, 32'h0000_0003, "divu_7by2");
        do_op(0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div_min_by_m1");
        do_op(0, OP_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div_7by_neg2");
        do_op(0, OP_MTHI,  32'hAAAA_0000, 32'd0,        0,  32'hAAAA_0000, 32'hFFFF_FFFD, "mthi_preload");
        do_op(0, OP_MTLO,  32'h0000_5555, 32'd0,        0,  32'hAAAA_0000, 32'h0000_5555, "mtlo_preload");
        do_op(0, OP_DIVU,  32'h0000_1234, 32'd0,        10, 32'hAAAA_0000, 32'h0000_5555, "divu_by_zero");

        // Start pulses at E3 (mult) and E4 (mtlo) of a div must be ignored.
        issue(0, OP_DIV, 32'd100, 32'd7, 1'b1, "div_intf", c);
        push_checks(0, c, 10, 32'd2, 32'd14, "div_intf");
        step(2);
        start0 = 1'b1; op0 = OP_MULT; a0 = 32'd3; b0 = 32'd3;
        push(cyc, 0, K_STALL, 32'd1, "intf_stall_e3");
        step(1);
        op0 = OP_MTLO; a0 = 32'hDEAD_BEEF;
        push(cyc, 0, K_STALL, 32'd1, "intf_stall_e4");
        step(1);
        start0 = 1'b0; op0 = OP_NONE;
        step(6);
        do_op(0, OP_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd42, "mult_after_div");

        // Reset at E3 of a mult discards the pending product.
        issue(0, OP_MULT, 32'd3, 32'd4, 1'b1, "mult_reset", c);
        for (int k = 0; k < 3; k++) begin
            push(c + 1 + k, 0, K_BUSY, 32'd1, "mult_reset");
            push(c + 1 + k, 0, K_HI, m_hi[0], "mult_reset");
            push(c + 1 + k, 0, K_LO, m_lo[0], "mult_reset");
        end
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
        for (int k = 0; k < 6; k++) begin
            push(cyc + k, 0, K_BUSY, 32'd0, "after_reset");
            push(cyc + k, 0, K_HI, 32'd0, "after_reset");
            push(cyc + k, 0, K_LO, 32'd0, "after_reset");
        end
        step(6);

        do_op(1, OP_MULT, 32'hF0, 32'h03, 1, 32'hFF, 32'hD0, "w8_mult");
        do_op(1, OP_DIV,  32'h80, 32'hFF, 3, 32'h00, 32'h80, "w8_div_min");
        do_op(1, OP_DIVU, 32'hF9, 32'h02, 3, 32'h01, 32'h7C, "w8_divu");
        do_op(1, OP_MTLO, 32'h5A, 32'h00, 0, 32'h01, 32'h5A, "w8_mtlo");

        step(3);
        while (sb.size() > 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s inst%0d %s: check for cycle %0d left unsampled",
                     sb[0].name, sb[0].inst, kname(sb[0].kind), sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multiply/divide unit: the sequential companion to the combinational ALU in the EX stage of the pipelined MIPS core. It executes mult, multu, div, divu, mthi and mtlo into private HI/LO registers, which are read combinationally for mfhi/mflo. Busy is exported to the hazard unit so later MDU instructions stall while an operation is in flight. Operand width and per-operation latency are parameters.

## Interface
- WIDTH, 32: operand, HI and LO width in bits (≥ 2).
- MULT_CYCLES, 5: busy cycles for mult/multu (≥ 1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥ 1).
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  issue strobe; MDUOp, SrcA and SrcB are sampled on this edge.
- MDUOp  in  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- SrcA  in  WIDTH  rs operand, or dividend.
- SrcB  in  WIDTH  rt operand, or divisor.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- Busy  out  1  registered; high while a mult/div is in flight.
- Stall  out  1  combinational: Busy | (Start & MDUOp in {1,2,3,4}).

## Operation
- Reset: HI=0, LO=0, Busy=0, cycle counter=0, operand latches=0. Any pending result is discarded.
- An issue is a rising edge with Start=1 and Busy=0. Start while Busy=1 is ignored entirely (no latch, no write). The hazard unit must prevent this case; the bench still checks it.
- mult/multu, issued:
  - Latch the operands and the op; load counter=MULT_CYCLES; Busy←1.
  - The product is 2·WIDTH bits: signed for mult, unsigned for multu.
  - Write {HI,LO} on completion.
- div/divu, issued:
  - Load counter=DIV_CYCLES.
  - LO←quotient, HI←remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - MIN/−1 (signed overflow): LO=MIN, HI=0.
  - Divisor 0: HI and LO are unchanged, but Busy still lasts the full DIV_CYCLES.
- mthi/mtlo, issued: on the same edge HI←SrcA (mthi) or LO←SrcA (mtlo). Busy stays 0.
- Counter: while Busy=1, it decrements on each edge. On the edge where the counter equals 1, the result is written, Busy←0 and counter←0.
- The result may be computed with a combinational operator on the latched operands and then delayed, or iteratively. In either case the output must match cycle-exactly; HI/LO must not change before completion.
- States: IDLE (Busy=0) and RUN (Busy=1).
  - IDLE→RUN on a mult/div issue.
  - RUN→IDLE on the completion edge, or on reset.
- Completion edge with Start=1 in the same cycle: Busy is still 1, so the new Start is ignored. A new issue is accepted from the following cycle. Stall covers this.

## Timing
- Issue at edge E0 (inputs set up before E0). Busy=1 after E0 through E(N−1); Busy=0 after EN, where N=MULT_CYCLES or DIV_CYCLES.
- HI/LO take the new value after EN and keep the old value before EN.
- mthi/mtlo: new value visible after the issuing edge (latency 1); HI/LO outputs are registers.
- Stall rises combinationally in the issue cycle, before Busy rises.
- Reset at any edge overrides Start and completion. Outputs are 0 after that edge.
- Back-to-back issue: the earliest second issue is at edge E(N+1).

## Test plan
- mult, SrcA=0xFFFFFFFD (−3), SrcB=5 -> Busy high for exactly 5 cycles; after E5 HI=0xFFFFFFFF, LO=0xFFFFFFF1; HI/LO unchanged at E1–E4.
- multu 0xFFFFFFFF×0xFFFFFFFF -> after E5 HI=0xFFFFFFFE, LO=0x00000001. Then mthi SrcA=0x12345678 -> HI=0x12345678 after one edge, Busy stays 0.
- div −7/2 -> after E10 LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/2 -> LO=3, HI=1. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- With HI=0xAAAA0000 and LO=0x5555 preloaded, divu by 0 -> Busy high for 10 cycles; HI/LO unchanged afterwards.
- During a div, pulse Start with mult at E3 and mtlo at E4 -> both ignored; div result lands at E10; Stall=1 throughout. A mult issued at E11 is accepted.
- reset asserted at E3 of a mult -> after E3 HI=LO=0 and Busy=0; no result is written later. Repeat with WIDTH=8, MULT_CYCLES=1: 8'hF0 × 8'h03 (signed) -> HI=0xFF, LO=0xD0 after one edge.
